// File: rtl/ahblite_interconnect_slaveport_if.sv
// Bundle of the per-masterport command/response signals and the single slave bus
// of one AHB-Lite interconnect slave port.
interface ahblite_interconnect_slaveport_if #(
  parameter int unsigned MASTER      = 2,
  parameter int unsigned HADDR_WIDTH = 32,
  parameter int unsigned HDATA_WIDTH = 32
);
  logic [MASTER-1:0]      mst_HSEL_i;
  logic [1:0]             mst_HTRANS_i    [MASTER];
  logic [2:0]             mst_HBURST_i    [MASTER];
  logic [2:0]             mst_HSIZE_i     [MASTER];
  logic                   mst_HWRITE_i    [MASTER];
  logic [HADDR_WIDTH-1:0] mst_HADDR_i     [MASTER];
  logic [HDATA_WIDTH-1:0] mst_HWDATA_i    [MASTER];
  logic                   mst_HMASTLOCK_i [MASTER];
  logic [6:0]             mst_HPROT_i     [MASTER];
  logic [MASTER-1:0]      mst_HREADY_o;
  logic [MASTER-1:0]      mst_HRESP_o;
  logic [HDATA_WIDTH-1:0] mst_HRDATA_o;

  logic                   slv_HSEL_o;
  logic [1:0]             slv_HTRANS_o;
  logic [2:0]             slv_HBURST_o;
  logic [2:0]             slv_HSIZE_o;
  logic                   slv_HWRITE_o;
  logic [HADDR_WIDTH-1:0] slv_HADDR_o;
  logic [HDATA_WIDTH-1:0] slv_HWDATA_o;
  logic                   slv_HMASTLOCK_o;
  logic [6:0]             slv_HPROT_o;
  logic                   slv_HREADY_o;
  logic [HDATA_WIDTH-1:0] slv_HRDATA_i;
  logic                   slv_HREADYOUT_i;
  logic                   slv_HRESP_i;

  logic [3:0]             aown_o;

  // View of the slave port itself
  modport slave (
    input  mst_HSEL_i, mst_HTRANS_i, mst_HBURST_i, mst_HSIZE_i, mst_HWRITE_i,
           mst_HADDR_i, mst_HWDATA_i, mst_HMASTLOCK_i, mst_HPROT_i,
           slv_HRDATA_i, slv_HREADYOUT_i, slv_HRESP_i,
    output mst_HREADY_o, mst_HRESP_o, mst_HRDATA_o,
           slv_HSEL_o, slv_HTRANS_o, slv_HBURST_o, slv_HSIZE_o, slv_HWRITE_o,
           slv_HADDR_o, slv_HWDATA_o, slv_HMASTLOCK_o, slv_HPROT_o, slv_HREADY_o,
           aown_o
  );

  // View of the surrounding masters and slave
  modport master (
    output mst_HSEL_i, mst_HTRANS_i, mst_HBURST_i, mst_HSIZE_i, mst_HWRITE_i,
           mst_HADDR_i, mst_HWDATA_i, mst_HMASTLOCK_i, mst_HPROT_i,
           slv_HRDATA_i, slv_HREADYOUT_i, slv_HRESP_i,
    input  mst_HREADY_o, mst_HRESP_o, mst_HRDATA_o,
           slv_HSEL_o, slv_HTRANS_o, slv_HBURST_o, slv_HSIZE_o, slv_HWRITE_o,
           slv_HADDR_o, slv_HWDATA_o, slv_HMASTLOCK_o, slv_HPROT_o, slv_HREADY_o,
           aown_o
  );
endinterface

// File: rtl/ahblite_interconnect_slaveport.sv
// AHB-Lite interconnect slave port: round-robin arbitration of several masterports
// onto one slave, with burst and lock retention and data-phase response routing.
module ahblite_interconnect_slaveport #(
  parameter int unsigned MASTER      = 2,
  parameter int unsigned HADDR_WIDTH = 32,
  parameter int unsigned HDATA_WIDTH = 32
) (
  input logic HCLK,
  input logic HRESET,
  ahblite_interconnect_slaveport_if.slave bus
);
  localparam int unsigned SEL_W = (MASTER > 1) ? $clog2(MASTER) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN = 2'd1, ST_LOCK = 2'd2} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SEL_W-1:0]       r_aown, r_down, r_ptr;
  logic [SEL_W-1:0]       w_aown_nxt, w_ptr_nxt, w_win;
  logic                   r_dvld;
  logic                   w_found, w_arb, w_owned, w_accept, w_own_lock;
  logic [1:0]             w_own_trans;
  logic [MASTER-1:0]      w_req, w_hready, w_hresp;
  logic [HADDR_WIDTH-1:0] w_haddr;
  logic [HDATA_WIDTH-1:0] w_hwdata;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= MASTER) s = s - MASTER;
    return SEL_W'(s);
  endfunction

  for (genvar g = 0; g < MASTER; g++) begin : g_port
    assign w_req[g] = bus.mst_HSEL_i[g] & bus.mst_HTRANS_i[g][1];
  end

  assign w_owned     = (r_state != ST_IDLE);
  assign w_own_trans = bus.mst_HTRANS_i[r_aown];
  assign w_own_lock  = bus.mst_HMASTLOCK_i[r_aown];
  assign w_accept    = w_owned & bus.mst_HSEL_i[r_aown] & w_own_trans[1];

  // Round-robin search starting one past the last winner
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < MASTER; k++) begin
      if (!w_found && w_req[wrap_inc(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_inc(r_ptr, k);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_aown  <= '0;
      r_ptr   <= '0;
    end else if (bus.slv_HREADYOUT_i) begin
      r_state <= w_state_nxt;
      r_aown  <= w_aown_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Ownership is kept through SEQ/BUSY beats, and through any beat while locked
  always_comb begin
    w_state_nxt = r_state;
    w_aown_nxt  = r_aown;
    w_ptr_nxt   = r_ptr;
    w_arb       = 1'b0;
    case (r_state)
      ST_IDLE: w_arb = 1'b1;
      ST_OWN:  w_arb = ~w_own_trans[0];
      ST_LOCK: w_arb = ~w_own_lock & ~w_own_trans[0];
      default: w_arb = 1'b1;
    endcase
    if (w_arb) begin
      if (w_found) begin
        w_state_nxt = bus.mst_HMASTLOCK_i[w_win] ? ST_LOCK : ST_OWN;
        w_aown_nxt  = w_win;
        w_ptr_nxt   = wrap_inc(w_win, 1);
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_down <= '0;
      r_dvld <= 1'b0;
    end else if (bus.slv_HREADYOUT_i) begin
      r_dvld <= w_accept;
      if (w_accept) r_down <= r_aown;
    end
  end

  // Responses go to the data owner; waiting requesters are stalled
  for (genvar g = 0; g < MASTER; g++) begin : g_resp
    logic w_dat, w_adr;
    assign w_dat      = r_dvld & (r_down == SEL_W'(g));
    assign w_adr      = w_owned & (r_aown == SEL_W'(g));
    assign w_hready[g] = (w_dat | w_adr) ? bus.slv_HREADYOUT_i : ~(w_req[g] & ~HRESET);
    assign w_hresp[g]  = w_dat & bus.slv_HRESP_i;
  end

  assign w_haddr  = w_owned ? bus.mst_HADDR_i[r_aown] : '0;
  assign w_hwdata = bus.mst_HWDATA_i[r_down];

  assign bus.slv_HSEL_o      = w_owned & bus.mst_HSEL_i[r_aown];
  assign bus.slv_HTRANS_o    = w_owned ? w_own_trans : 2'b00;
  assign bus.slv_HBURST_o    = w_owned ? bus.mst_HBURST_i[r_aown] : 3'b000;
  assign bus.slv_HSIZE_o     = w_owned ? bus.mst_HSIZE_i[r_aown] : 3'b000;
  assign bus.slv_HWRITE_o    = w_owned & bus.mst_HWRITE_i[r_aown];
  assign bus.slv_HADDR_o     = w_haddr;
  assign bus.slv_HMASTLOCK_o = w_owned & w_own_lock;
  assign bus.slv_HPROT_o     = w_owned ? bus.mst_HPROT_i[r_aown] : 7'd0;
  assign bus.slv_HWDATA_o    = w_hwdata;
  assign bus.slv_HREADY_o    = bus.slv_HREADYOUT_i;
  assign bus.mst_HRDATA_o    = bus.slv_HRDATA_i;
  assign bus.mst_HREADY_o    = w_hready;
  assign bus.mst_HRESP_o     = w_hresp;
  assign bus.aown_o          = 4'(r_aown);
endmodule
